branch_resolution_queue: RTL
============================

# branch_resolution_queue

In-order queue that sits directly downstream of the tournament predictor. At fetch it records each predicted branch's PC, the global history the predictor used, and the predicted direction. At execute it matches the resolved outcome against the oldest entry and drives the predictor's training port (`write_enabled`, `pc_bits_write`, `history_write`, `outcome`). On a misprediction it raises a one-cycle mispredict pulse with corrected history and flushes every younger entry.

## Interface
- `HISTORY_LEN`, 8: global history width; matches the predictor.
- `DEPTH`, 8: maximum in-flight branches; power of two, at least 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `alloc_valid`  in  1  fetch presents a predicted branch.
- `alloc_ready`  out  1  queue can accept; equals `!full`.
- `alloc_pc`  in  16  branch PC bits as given to the predictor's read port.
- `alloc_history`  in  HISTORY_LEN  predictor `history_read` at prediction time.
- `alloc_prediction`  in  1  predictor `prediction`.
- `resolve_valid`  in  1  oldest in-flight branch resolved this cycle.
- `resolve_taken`  in  1  actual direction.
- `write_enabled`  out  1  training strobe to the predictor.
- `pc_bits_write`  out  16  PC of the trained entry.
- `history_write`  out  HISTORY_LEN  stored history of the trained entry.
- `outcome`  out  1  actual direction for training.
- `mispredict`  out  1  one-cycle pulse on a wrong prediction.
- `recover_history`  out  HISTORY_LEN  `{history_write[HISTORY_LEN-2:0], outcome}`, valid while `mispredict` is high.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer with `head` and `tail` pointers, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH, plus `count`.
  - Full is `count==DEPTH`. Empty is `count==0`.
- Allocate: when `alloc_valid && alloc_ready`, write `{pc, history, prediction}` at `tail` and increment `tail`.
- Resolve: when `resolve_valid && !empty`, read the entry at `head` and increment `head`. Next cycle:
  - `write_enabled`=1 and the training outputs carry the stored fields, with `outcome`=`resolve_taken`.
  - `mispredict` = `resolve_taken != stored prediction`.
- Resolve while empty is ignored: no training, no pointer movement.
- Mispredict flush:
  - In the resolving cycle, set `tail` = `head+1` and `count`=0.
  - An allocation in the same cycle is dropped. It was fetched down the wrong path.
- Allocate and resolve in the same cycle without a mispredict: both happen and `count` is unchanged.
  - When full, `alloc_ready`=0 even if a resolve occurs. There is no bypass.
- Resolution is strictly in order. The execute stage guarantees oldest-first.
- Mid-operation reset discards all entries and returns every output to its reset value immediately.

## Timing
- Reset values: `write_enabled`=0, `mispredict`=0, `pc_bits_write`=0, `history_write`=0, `outcome`=0, `recover_history`=0, `count`=0, `alloc_ready`=1.
- Training outputs and `mispredict` are registered and appear exactly 1 cycle after the resolve edge.
  - `write_enabled` and `mispredict` are single-cycle pulses.
  - The other training outputs hold their last values between pulses.
- `alloc_ready` and `count` are registered-state derived. `alloc_ready` has no combinational path from `resolve_valid`.
- Back-to-back resolves every cycle give back-to-back training pulses at full throughput.
- An entry allocated at edge N is resolvable at edge N+1 or later.

## Structure
- Shared package `bp_pkg`:
  - `HISTORY_LEN` default.
  - Entry width constant `BRQ_ENTRY_W = 16+HISTORY_LEN+1`.
  - Field offsets for pc, history and prediction within an entry.
- One sub-module, `brq_storage`: a DEPTH×BRQ_ENTRY_W register array with one write port and one asynchronous read port. It is not reset; validity comes from `count`.
- Pointer, count and flush logic and the output registers live in the top module.

## Test plan
- Reset then idle: all outputs at reset values; `alloc_ready`=1 and `count`=0 for 10 cycles.
- Allocate pc=0x0040, hist=0xA5, pred=1, then resolve taken=1: one cycle later `write_enabled`=1, `pc_bits_write`=0x0040, `history_write`=0xA5, `outcome`=1, `mispredict`=0, `count`=0.
- Fill to 8, hold `alloc_valid` high: `alloc_ready`=0 and `count`=8. Resolve all 8 back-to-back: 8 consecutive training pulses in FIFO order, pointers wrap, `count` returns to 0.
- Allocate 3 entries (pred 0, 1, 1), resolve the first as taken=1 with a same-cycle allocation: `mispredict`=1, `recover_history`={hist0[6:0],1}, `count`=0, the new allocation dropped.
- Resolve while empty: no `write_enabled` pulse and `count` stays 0. Simultaneous allocate and correct resolve at count=4: `count` stays 4.
- Assert reset mid-stream at count=5: `count`=0 and outputs cleared asynchronously. Allocation works on the first edge after release.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared predictor constants and the branch queue entry layout.
package bp_pkg;
    localparam int HISTORY_LEN  = 8;
    localparam int BRQ_ENTRY_W  = 16 + HISTORY_LEN + 1;
    // Entry is {pc, history, prediction}, prediction in the LSB.
    localparam int BRQ_PRED_OFF = 0;
    localparam int BRQ_HIST_OFF = 1;
    localparam int BRQ_PC_OFF   = BRQ_HIST_OFF + HISTORY_LEN;
endpackage

// File: rtl/brq_storage.sv
// brq_storage: unreset entry array, one write port, one asynchronous read port.
module brq_storage #(
    parameter int DEPTH = 8,
    parameter int W     = 25
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: in-order queue of predicted branches that trains
// the predictor at resolve and flushes younger entries on a mispredict.
module branch_resolution_queue #(
    parameter int HISTORY_LEN = 8,
    parameter int DEPTH       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [15:0]                alloc_pc_i,
    input  logic [HISTORY_LEN-1:0]     alloc_history_i,
    input  logic                       alloc_prediction_i,
    input  logic                       resolve_valid_i,
    input  logic                       resolve_taken_i,
    output logic                       write_enabled_o,
    output logic [15:0]                pc_bits_write_o,
    output logic [HISTORY_LEN-1:0]     history_write_o,
    output logic                       outcome_o,
    output logic                       mispredict_o,
    output logic [HISTORY_LEN-1:0]     recover_history_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    import bp_pkg::*;

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int EW     = 16 + HISTORY_LEN + 1;
    localparam int PC_OFF = BRQ_HIST_OFF + HISTORY_LEN;

    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic [EW-1:0]          rd_entry;
    logic                   do_res, do_alloc, mis;
    logic                   we_q, mis_q, outcome_q;
    logic [15:0]            pc_q;
    logic [HISTORY_LEN-1:0] hist_q;

    brq_storage #(.DEPTH(DEPTH), .W(EW)) u_storage (
        .clk_i   (clk_i),
        .we_i    (do_alloc),
        .waddr_i (tail_q),
        .wdata_i ({alloc_pc_i, alloc_history_i, alloc_prediction_i}),
        .raddr_i (head_q),
        .rdata_o (rd_entry)
    );

    assign alloc_ready_o = count_q != CW'(DEPTH);

    // A mispredict empties the queue; the same-cycle allocation is wrong-path.
    always_comb begin
        do_res   = resolve_valid_i && count_q != '0;
        mis      = do_res && (resolve_taken_i != rd_entry[BRQ_PRED_OFF]);
        do_alloc = alloc_valid_i && alloc_ready_o && !mis;
        head_d   = head_q + PW'(do_res);
        tail_d   = mis ? head_q + PW'(1) : tail_q + PW'(do_alloc);
        count_d  = mis ? '0 : count_q + CW'(do_alloc) - CW'(do_res);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            mis_q     <= 1'b0;
            pc_q      <= '0;
            hist_q    <= '0;
            outcome_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= do_res;
            mis_q   <= mis;
            if (do_res) begin
                pc_q      <= rd_entry[PC_OFF +: 16];
                hist_q    <= rd_entry[BRQ_HIST_OFF +: HISTORY_LEN];
                outcome_q <= resolve_taken_i;
            end
        end
    end

    assign write_enabled_o   = we_q;
    assign mispredict_o      = mis_q;
    assign pc_bits_write_o   = pc_q;
    assign history_write_o   = hist_q;
    assign outcome_o         = outcome_q;
    assign recover_history_o = {hist_q[HISTORY_LEN-2:0], outcome_q};
    assign count_o           = count_q;
endmodule
